// File: rtl/alu_hs_pkg.sv
// alu_hs_pkg: opcode encoding, FSM states and result-layout helper for alu_hs
package alu_hs_pkg;
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_NAND = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_XNOR = 4'b1001;
  localparam logic [3:0] OP_CMPE = 4'b1010;
  localparam logic [3:0] OP_CMPG = 4'b1011;
  localparam logic [3:0] OP_SFTR = 4'b1100;
  localparam logic [3:0] OP_SFTL = 4'b1101;
  localparam logic [3:0] OP_ROTR = 4'b1110;
  localparam logic [3:0] OP_ROTL = 4'b1111;
  typedef enum logic {IDLE, DIV_BUSY} state_t;
  function automatic int rem_lsb(input int data_w);
    return data_w;
  endfunction
endpackage

// File: rtl/alu_div_iter.sv
// alu_div_iter: unsigned restoring divider, one quotient bit per cycle over DATA_W cycles
module alu_div_iter #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);
  logic              busy;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rem, quo, dvs, rem_n, quo_n;
  logic [DATA_W:0]   shifted, trial;
  logic              fits;
  assign shifted = {rem, quo[DATA_W-1]};
  assign trial   = shifted - {1'b0, dvs};
  assign fits    = !trial[DATA_W];
  assign rem_n   = fits ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
  assign quo_n   = {quo[DATA_W-2:0], fits};
  // outputs expose the final step so the caller can register them on the done edge
  assign done      = busy & (cnt == '0);
  assign quotient  = quo_n;
  assign remainder = rem_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      rem  <= '0;
      quo  <= '0;
      dvs  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= CNT_W'(DATA_W - 1);
      rem  <= '0;
      quo  <= dividend;
      dvs  <= divisor;
    end else if (busy) begin
      rem  <= rem_n;
      quo  <= quo_n;
      cnt  <= cnt - 1'b1;
      busy <= cnt != '0;
    end
  end
endmodule

// File: rtl/alu_hs.sv
// alu_hs: handshaked ALU with signed mode, shifts/rotates, status flags and an iterative divider
module alu_hs import alu_hs_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int ALU_OP = 4,
  parameter int SH_W   = $clog2(DATA_W)
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                InValid,
  output logic                InReady,
  input  logic [ALU_OP-1:0]   AluFun,
  input  logic                SignedMode,
  input  logic [DATA_W-1:0]   OpA,
  input  logic [DATA_W-1:0]   OpB,
  output logic [2*DATA_W-1:0] AluOut,
  output logic                OutValid,
  input  logic                OutReady,
  output logic                FlagZero,
  output logic                FlagCarry,
  output logic                FlagDivZero
);
  localparam int OW      = 2 * DATA_W;
  localparam int REM_LSB = rem_lsb(DATA_W);
  state_t            state_q, state_d;
  logic              accept, start, load, div_done, gt;
  logic [SH_W-1:0]   sh;
  logic [DATA_W:0]   sum, dif;
  logic [DATA_W-1:0] sra, nres, div_quo, div_rem;
  logic [OW-1:0]     uprod, sprod, prod, dup, rot_r, rot_l, op_res, div_res, res;
  assign sh    = OpB[SH_W-1:0];
  assign sum   = {1'b0, OpA} + {1'b0, OpB};
  assign dif   = {1'b0, OpA} - {1'b0, OpB};
  assign uprod = {{DATA_W{1'b0}}, OpA} * {{DATA_W{1'b0}}, OpB};
  assign sprod = {{DATA_W{OpA[DATA_W-1]}}, OpA} * {{DATA_W{OpB[DATA_W-1]}}, OpB};
  assign prod  = SignedMode ? sprod : uprod;
  assign gt    = SignedMode ? ($signed(OpA) > $signed(OpB)) : (OpA > OpB);
  assign sra   = $signed(OpA) >>> sh;
  assign dup   = {OpA, OpA};
  assign rot_r = dup >> sh;
  assign rot_l = dup << sh;
  always_comb begin
    nres = '0;
    case (AluFun)
      OP_AND:  nres = OpA & OpB;
      OP_OR:   nres = OpA | OpB;
      OP_NAND: nres = ~(OpA & OpB);
      OP_NOR:  nres = ~(OpA | OpB);
      OP_XOR:  nres = OpA ^ OpB;
      OP_XNOR: nres = ~(OpA ^ OpB);
      OP_CMPE: nres = {{(DATA_W-1){1'b0}}, OpA == OpB};
      OP_CMPG: nres = {{(DATA_W-1){1'b0}}, gt};
      OP_SFTR: nres = SignedMode ? sra : OpA >> sh;
      OP_SFTL: nres = OpA << sh;
      OP_ROTR: nres = rot_r[DATA_W-1:0];
      OP_ROTL: nres = rot_l[OW-1:DATA_W];
      default: nres = '0;
    endcase
  end
  // the DIV arm here only serves the divide-by-zero shortcut
  assign op_res = AluFun == OP_ADD ? {{(DATA_W-1){1'b0}}, sum} :
                  AluFun == OP_SUB ? {{(DATA_W-1){1'b0}}, dif} :
                  AluFun == OP_MUL ? prod :
                  AluFun == OP_DIV ? {OpA, {DATA_W{1'b1}}} :
                  {{DATA_W{1'b0}}, nres};
  always_comb begin
    div_res = '0;
    div_res[REM_LSB +: DATA_W] = div_rem;
    div_res[DATA_W-1:0] = div_quo;
  end
  assign res     = div_done ? div_res : op_res;
  assign InReady = (state_q == IDLE) & (!OutValid | OutReady);
  assign accept  = InValid & InReady;
  assign start   = accept & (AluFun == OP_DIV) & (OpB != '0);
  assign load    = (accept & !start) | div_done;
  assign state_d = start ? DIV_BUSY : div_done ? IDLE : state_q;
  alu_div_iter #(.DATA_W(DATA_W)) u_div (
    .clk(Clk),
    .rst(Reset),
    .start(start),
    .dividend(OpA),
    .divisor(OpB),
    .done(div_done),
    .quotient(div_quo),
    .remainder(div_rem)
  );
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      OutValid    <= 1'b0;
      AluOut      <= '0;
      FlagZero    <= 1'b0;
      FlagCarry   <= 1'b0;
      FlagDivZero <= 1'b0;
    end else begin
      state_q  <= state_d;
      OutValid <= load | (OutValid & !OutReady);
      if (load) begin
        AluOut      <= res;
        FlagZero    <= res == '0;
        FlagCarry   <= !div_done & ((AluFun == OP_ADD) | (AluFun == OP_SUB)) & res[DATA_W];
        FlagDivZero <= !div_done & (AluFun == OP_DIV) & (OpB == '0);
      end
    end
  end
endmodule

// File: doc/alu_hs.md
Name: alu_hs

Overview:
- Next-generation ALU for the UART command datapath. It replaces the single-cycle, fire-and-forget ALU with three additions:
  - a valid/ready handshake on both input and output;
  - an iterative multi-cycle divider;
  - signed mode, variable shift/rotate amounts and status flags.
- Sits between the register file/command decoder and the UART TX framer.
- Holds its result under output backpressure.

Parameters:
- DATA_W, 8, operand width in bits (min 4).
- ALU_OP, 4, opcode width (fixed encoding below uses all 16 codes).
- SH_W, $clog2(DATA_W), width of shift/rotate amount taken from OpB[SH_W-1:0].

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- InValid  in  1  operation request.
- InReady  out  1  block can accept an operation this cycle.
- AluFun  in  ALU_OP  opcode.
- SignedMode  in  1  signed interpretation for MUL, CMPG, SFTR.
- OpA  in  DATA_W  operand A.
- OpB  in  DATA_W  operand B.
- AluOut  out  2*DATA_W  result.
- OutValid  out  1  result valid.
- OutReady  in  1  consumer accepts result.
- FlagZero  out  1  AluOut == 0.
- FlagCarry  out  1  ADD carry-out / SUB borrow (AluOut[DATA_W]); 0 for other ops.
- FlagDivZero  out  1  DIV with OpB == 0.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are named Clk and Reset.
- Reset values: AluOut=0, OutValid=0, all flags 0, state IDLE, divider counter 0. InReady=1 in the cycle after Reset deasserts.
- Reset mid-division or mid-hold aborts the operation; no result is emitted.
- Acceptance:
  - An operation is accepted when InValid & InReady at a rising edge.
  - Operands and opcode are captured in that cycle.
- InReady = (state==IDLE) & (!OutValid | OutReady). This is combinational and allows back-to-back acceptance when the result drains in the same cycle.
- Opcodes:
  - ADD 0000, SUB 0001, MUL 0010, DIV 0011
  - AND 0100, OR 0101, NAND 0110, NOR 0111
  - XOR 1000, XNOR 1001, CMPE 1010, CMPG 1011
  - SFTR 1100, SFTL 1101, ROTR 1110, ROTL 1111
- Width rules:
  - Logic ops, SFTR/SFTL/ROTR/ROTL: zero-extended into AluOut.
  - ADD/SUB: DATA_W+1 result, zero-extended.
  - MUL: full 2*DATA_W product; signed if SignedMode.
  - CMPE/CMPG: 1 or 0; CMPG is signed compare if SignedMode.
  - SFTR: arithmetic if SignedMode, else logical.
  - Shift/rotate amount = OpB[SH_W-1:0]; amount 0 passes OpA through.
- Latency:
  - Every op except DIV with nonzero divisor: OutValid rises on the edge after acceptance (1 cycle).
  - DIV with nonzero divisor: unsigned restoring divider, one quotient bit per cycle. OutValid rises DATA_W+1 edges after acceptance.
- DIV output: AluOut[2*DATA_W-1:DATA_W] = remainder; AluOut[DATA_W-1:0] = quotient. SignedMode is ignored for DIV.
- DIV by zero: 1-cycle latency, quotient = all ones, remainder = OpA, FlagDivZero=1.
- State machine:
  - IDLE: on accepting DIV with OpB!=0, go to DIV_BUSY; on any other acceptance, stay in IDLE and register the result.
  - DIV_BUSY: counter runs DATA_W-1 down to 0. At 0, register the result, set OutValid and return to IDLE.
  - InReady=0 throughout DIV_BUSY.
- Output hold:
  - While OutValid & !OutReady, AluOut and the flags are held stable and no new op is accepted.
  - OutValid clears on an OutReady handshake unless a new result is registered in the same cycle.
- Flags are registered together with AluOut and are valid only while OutValid=1.

Decomposition:
- Package alu_hs_pkg holds:
  - the opcode localparams (ADD..ROTL);
  - the state encoding (IDLE, DIV_BUSY);
  - the result-layout helper constants (REM_LSB = DATA_W).
- One sub-module, alu_div_iter: start/busy/done interface with dividend, divisor, quotient and remainder outputs; DATA_W-cycle restoring divider.
- Combinational ops and the handshake FSM stay in alu_hs.

Test Plan (DATA_W=8):
- ADD 0xC8+0x64, OutReady=1 -> 1 cycle later AluOut=0x012C, FlagCarry=1, FlagZero=0, OutValid for 1 cycle.
- DIV 100/7 -> InReady=0 for 8 cycles; OutValid 9 edges after acceptance with AluOut=0x020E (rem 2, quot 14).
- DIV 0x55/0 -> 1 cycle later AluOut=0x55FF, FlagDivZero=1.
- SignedMode=1:
  - MUL 0xFD*0x05 -> AluOut=0xFFF1.
  - SFTR 0x80 by 3 -> 0x00F0.
  - ROTL 0x81 by 1 -> 0x0003.
- Backpressure:
  - Hold OutReady=0 for 3 cycles after a SUB 5-7 result -> AluOut=0x01FE held stable, FlagCarry=1, InReady=0.
  - Assert OutReady with a new InValid -> back-to-back accept, next result the following cycle.
- Reset asserted on cycle 4 of a DIV -> next cycle OutValid=0, AluOut=0, InReady=1; no stale result appears afterwards.
